// File: rtl/romulus_rdi_prng_pkg.sv
// Shared constants and types for the Romulus randomness source.
package romulus_rdi_prng_pkg;

  localparam int unsigned RNDW_DEFAULT = 64;
  localparam int unsigned PRNG_SEEDW   = 128;
  localparam int unsigned PRNG_STEPW   = 32;

  // Generator state; x occupies the top lane so it lines up with seed_data.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } xs_state_t;

  // xorshift128 has an all-zero fixed point, so a zero seed is swapped for this.
  localparam logic [PRNG_SEEDW-1:0] ZERO_SEED_SUB =
    {32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};

  localparam logic [1:0] ST_UNSEEDED = 2'd0;
  localparam logic [1:0] ST_FILL     = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;

endpackage

// File: rtl/romulus_rdi_prng_if.sv
// Seed input and rdi output bundle between the PRNG and its neighbours.
interface romulus_rdi_prng_if
  import romulus_rdi_prng_pkg::*;
#(
  parameter int unsigned RNDW = RNDW_DEFAULT
);
  logic [PRNG_SEEDW-1:0] seed_data;
  logic                  seed_valid;
  logic                  seed_ready;
  logic [RNDW-1:0]       rdi_data;
  logic                  rdi_valid;
  logic                  rdi_ready;
  logic                  reseed_req;

  // PRNG side
  modport master (
    input  seed_data, seed_valid, rdi_ready,
    output seed_ready, rdi_data, rdi_valid, reseed_req
  );

  // Seed source / LWC core side
  modport slave (
    output seed_data, seed_valid, rdi_ready,
    input  seed_ready, rdi_data, rdi_valid, reseed_req
  );
endinterface

// File: rtl/romulus_xorshift128_step.sv
// One combinational xorshift128 step: next state plus the 32-bit word it yields.
module romulus_xorshift128_step
  import romulus_rdi_prng_pkg::*;
(
  input  xs_state_t   state_i,
  output xs_state_t   next_state_c_o,
  output logic [31:0] word_c_o
);
  logic [31:0] t_c;
  logic [31:0] w_c;

  // Marsaglia xorshift128 recurrence, all 32-bit
  always_comb begin
    t_c            = state_i.x ^ (state_i.x << 11);
    w_c            = state_i.w ^ (state_i.w >> 19) ^ t_c ^ (t_c >> 8);
    next_state_c_o = '{x: state_i.y, y: state_i.z, z: state_i.w, w: w_c};
    word_c_o       = w_c;
  end
endmodule

// File: rtl/romulus_rdi_prng.sv
// Seeded xorshift128 randomness source feeding the Romulus rdi port.
module romulus_rdi_prng
  import romulus_rdi_prng_pkg::*;
#(
  parameter int unsigned RNDW            = RNDW_DEFAULT,
  parameter int unsigned RESEED_INTERVAL = 1024
) (
  input logic                clk,
  input logic                rst,
  romulus_rdi_prng_if.master bus
);
  localparam int unsigned WORDS = RNDW / PRNG_STEPW;
  localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNTW  = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(RESEED_INTERVAL);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  xs_state_t       xs_q, xs_d;
  logic [RNDW-1:0] fill_q, fill_d;
  logic [RNDW-1:0] slot_q, slot_d;
  logic            valid_q, valid_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            seed_rdy_q;

  xs_state_t   step_state_c;
  logic [31:0] step_word_c;
  logic        seed_acc_c;
  logic        consume_c;
  logic        slot_free_c;

  romulus_xorshift128_step u_step (
    .state_i        (xs_q),
    .next_state_c_o (step_state_c),
    .word_c_o       (step_word_c)
  );

  assign seed_acc_c  = bus.seed_valid && seed_rdy_q;
  assign consume_c   = valid_q && bus.rdi_ready;
  assign slot_free_c = !valid_q || bus.rdi_ready;

  // Next state for FSM, generator, fill buffer and output slot
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xs_d    = xs_q;
    fill_d  = fill_q;
    slot_d  = slot_q;
    valid_d = valid_q;

    if (consume_c) begin
      valid_d = 1'b0;
    end

    if (seed_acc_c) begin
      // A new seed restarts the group; whatever sits in the slot is still delivered.
      xs_d    = (bus.seed_data == '0) ? xs_state_t'(ZERO_SEED_SUB) : xs_state_t'(bus.seed_data);
      state_d = ST_FILL;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_UNSEEDED: ;
        ST_FILL: begin
          xs_d = step_state_c;
          for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx_q == IDXW'(k)) fill_d[k*PRNG_STEPW +: PRNG_STEPW] = step_word_c;
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_FULL;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        ST_FULL: begin
          if (slot_free_c) begin
            // Hand the group over and produce word 0 of the next group in the
            // same cycle, so a group costs WORDS cycles end to end.
            slot_d  = fill_q;
            valid_d = 1'b1;
            xs_d    = step_state_c;
            fill_d[PRNG_STEPW-1:0] = step_word_c;
            if (WORDS == 1) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_FILL;
              idx_d   = IDXW'(1);
            end
          end
        end
        default: state_d = ST_UNSEEDED;
      endcase
    end
  end

  // Delivered-word counter and advisory reseed request; a seed accept wins over a consume
  always_comb begin
    cnt_d = cnt_q;
    if (seed_acc_c) begin
      cnt_d = '0;
    end else if (consume_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    req_d = (RESEED_INTERVAL != 0) && (cnt_d == CNT_MAX);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_UNSEEDED;
      idx_q      <= '0;
      xs_q       <= '0;
      fill_q     <= '0;
      slot_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      seed_rdy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      xs_q       <= xs_d;
      fill_q     <= fill_d;
      slot_q     <= slot_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      seed_rdy_q <= 1'b1;
    end
  end

  assign bus.seed_ready = seed_rdy_q;
  assign bus.rdi_data   = slot_q;
  assign bus.rdi_valid  = valid_q;
  assign bus.reseed_req = req_q;

endmodule

// File: tb/tb_romulus_rdi_prng.sv
// Directed bench for romulus_rdi_prng with a queue of expected rdi words.
module tb_romulus_rdi_prng;
  localparam int unsigned RNDW = 64;
  localparam logic [127:0] GOLD_SEED =
    {32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
  localparam logic [127:0] ALT_SEED =
    {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0BADF00D};
  localparam logic [63:0] GOLD_WORD0 = 64'h1B5116E6_DCA345EA;
  localparam int WAIT_MAX = 40;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   last_wait;
  logic [127:0] ms;
  logic [63:0]  exp_q[$];

  romulus_rdi_prng_if #(.RNDW(RNDW)) bus ();

  romulus_rdi_prng #(.RNDW(RNDW), .RESEED_INTERVAL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference xorshift128: advance the model and queue n packed words
  task automatic push_words(input int n);
    logic [63:0] g;
    logic [31:0] t;
    logic [31:0] nw;
    for (int i = 0; i < n; i++) begin
      g = '0;
      for (int k = 0; k < 2; k++) begin
        t  = ms[127:96] ^ (ms[127:96] << 11);
        nw = ms[31:0] ^ (ms[31:0] >> 19) ^ t ^ (t >> 8);
        ms = {ms[95:0], nw};
        g[k*32 +: 32] = nw;
      end
      exp_q.push_back(g);
    end
  endtask

  // Offer a seed for one cycle; returns at the negedge after the accept edge
  task automatic do_seed(input logic [127:0] seed, input int nwords);
    bus.seed_data  = seed;
    bus.seed_valid = 1'b1;
    ms = (seed == '0) ? GOLD_SEED : seed;
    exp_q.delete();
    push_words(nwords);
    tick();
    bus.seed_valid = 1'b0;
  endtask

  // Wait (bounded) for rdi_valid, then compare rdi_data with the scoreboard head
  task automatic await_word(input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    while (bus.rdi_valid !== 1'b1 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    last_wait = n;
    check({tag, "_timeout"}, 128'(n < WAIT_MAX), 128'(1));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    check(tag, 128'(bus.rdi_data), 128'(exp));
  endtask

  initial begin
    logic stable;
    logic [63:0] held;
    logic saw_valid;
    n_assert = 0;
    n_fail   = 0;
    rst            = 1'b0;
    bus.seed_data  = '0;
    bus.seed_valid = 1'b0;
    bus.rdi_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_seed_ready", 128'(bus.seed_ready), 128'(1));
    check("rst_rdi_valid", 128'(bus.rdi_valid), 128'(0));
    check("rst_rdi_data", 128'(bus.rdi_data), 128'(0));
    check("rst_reseed_req", 128'(bus.reseed_req), 128'(0));
    rst = 1'b1;
    tick();
    check("unseeded_no_valid", 128'(bus.rdi_valid), 128'(0));

    // Golden sequence, latency and sustained throughput
    bus.rdi_ready = 1'b1;
    do_seed(GOLD_SEED, 4);
    await_word("gold_w0");
    check("gold_latency", 128'(last_wait), 128'(3));
    check("gold_w0_const", 128'(bus.rdi_data), 128'(GOLD_WORD0));
    tick();
    await_word("gold_w1");
    check("gold_gap_w1", 128'(last_wait + 1), 128'(2));
    tick();
    await_word("gold_w2");
    check("gold_gap_w2", 128'(last_wait + 1), 128'(2));
    tick();

    // Zero seed falls back to the golden substitute
    do_seed(128'h0, 2);
    await_word("zero_w0");
    check("zero_w0_const", 128'(bus.rdi_data), 128'(GOLD_WORD0));
    check("zero_latency", 128'(last_wait), 128'(3));
    tick();

    // Backpressure: word held for 20 cycles, next follows with no bubble
    bus.rdi_ready = 1'b0;
    do_seed(ALT_SEED, 3);
    await_word("bp_w0");
    held   = bus.rdi_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rdi_valid !== 1'b1 || bus.rdi_data !== held) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'(1));
    bus.rdi_ready = 1'b1;
    tick();
    check("bp_no_bubble", 128'(bus.rdi_valid), 128'(1));
    await_word("bp_w1");
    check("bp_w1_wait", 128'(last_wait), 128'(0));
    tick();

    // Reseed request after the 4th handshake, cleared by the next seed accept
    do_seed(GOLD_SEED, 6);
    for (int i = 0; i < 4; i++) begin
      await_word($sformatf("req_w%0d", i));
      check($sformatf("req_low_%0d", i), 128'(bus.reseed_req), 128'(0));
      tick();
    end
    check("req_high", 128'(bus.reseed_req), 128'(1));
    await_word("req_w4");
    check("req_saturated", 128'(bus.reseed_req), 128'(1));
    tick();
    do_seed(GOLD_SEED, 2);
    check("req_cleared", 128'(bus.reseed_req), 128'(0));

    // Mid-fill reseed: partial group from the old seed is dropped
    tick();
    do_seed(ALT_SEED, 2);
    await_word("midfill_w0");
    check("midfill_latency", 128'(last_wait), 128'(3));
    check("midfill_req", 128'(bus.reseed_req), 128'(0));
    tick();

    // Reset while a word is pending
    bus.rdi_ready = 1'b0;
    do_seed(GOLD_SEED, 1);
    await_word("prereset_w0");
    rst = 1'b0;
    tick();
    check("mid_rst_valid", 128'(bus.rdi_valid), 128'(0));
    check("mid_rst_seed_ready", 128'(bus.seed_ready), 128'(1));
    check("mid_rst_data", 128'(bus.rdi_data), 128'(0));
    check("mid_rst_req", 128'(bus.reseed_req), 128'(0));
    rst = 1'b1;
    bus.rdi_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rdi_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("post_rst_silent", 128'(saw_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/romulus_rdi_prng.md
Name: romulus_rdi_prng

Overview:
- Randomness source that sits directly upstream of the protected Romulus LWC core.
- Drives the core's rdi_data / rdi_valid inputs and consumes its rdi_ready.
- Expands a 128-bit seed with a xorshift128 generator: 32 bits per step, packed into RNDW-bit words.
- Requests a reseed after a configurable number of delivered words.

Parameters:
RNDW, 64, output word width; must be a multiple of 32 and at least 32
RESEED_INTERVAL, 1024, number of delivered words after which reseed_req asserts; 0 disables the request

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
seed_data  input  128  seed {x,y,z,w}; x=[127:96], w=[31:0]
seed_valid  input  1  seed offered
seed_ready  output  1  seed accepted when seed_valid && seed_ready
rdi_data  output  RNDW  random word to the LWC core
rdi_valid  output  1  rdi_data valid
rdi_ready  input  1  core accepts the word
reseed_req  output  1  interval expired; cleared by the next seed accept

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: seed_ready=1, rdi_valid=0, rdi_data=0, reseed_req=0.
  - State: FSM=UNSEEDED, word counters=0, fill buffer empty.
- Generator step, one per cycle while in FILL:
  - t = x ^ (x<<11); x<=y; y<=z; z<=w; w<=w ^ (w>>19) ^ t ^ (t>>8).
  - All arithmetic is 32-bit, and the new w is the produced word.
- Packing: the k-th word of a group lands in fill[32k+31:32k]; a group is WORDS=RNDW/32 words.
- Zero seed: an all-zero seed is replaced by {123456789, 362436069, 521288629, 88675123}.
- FSM states:
  - UNSEEDED: seed_ready=1, no generation. A seed accept loads the state and goes to FILL.
  - FILL: one step per cycle, word index 0..WORDS-1. After the last word, go to FULL.
  - FULL: the fill buffer is complete and waits for the output slot. Transfer to the slot happens when the slot is empty or is being consumed in the same cycle; then go to FILL.
- Output slot:
  - rdi_valid rises in the cycle after the transfer.
  - rdi_data is held stable while rdi_valid && !rdi_ready.
  - Transfer and consume in the same cycle keep rdi_valid high with new data; no bubble.
- Latency and throughput:
  - First rdi_valid appears WORDS+1 cycles after the seed accept edge.
  - Sustained throughput is one word per WORDS cycles.
- Reseed outside UNSEEDED:
  - seed_ready=1 in FILL and FULL.
  - A seed accept reloads the state and discards the partial fill: index=0, state FILL.
  - A word already in the output slot is kept and delivered.
  - The delivered-word counter clears and reseed_req drops on the accept edge.
- reseed_req:
  - Counts delivered words (rdi_valid && rdi_ready), saturating at RESEED_INTERVAL.
  - reseed_req=1 while count==RESEED_INTERVAL; generation continues, the request is advisory.
- Simultaneous seed accept and output consume: both take effect and the counter clears, because the seed wins.

Decomposition:
- Shared package (alongside the Romulus config): RNDW default, PRNG_SEEDW=128, the zero-seed substitute constant, and FSM state encodings.
- One sub-module: romulus_xorshift128_step, purely combinational; maps 128-bit state to the next state plus a 32-bit word.
- The FSM, fill buffer, output slot and counters stay in the top module.

Test Plan:
- Golden sequence: RNDW=64, seed {123456789,362436069,521288629,88675123}, rdi_ready=1 → first rdi_data=64'h1B5116E6_DCA345EA, rdi_valid at seed accept + 3 cycles.
- Zero seed: seed 128'h0 → rdi_data identical to the golden test.
- Backpressure: hold rdi_ready=0 for 20 cycles after valid → rdi_data stable and rdi_valid high throughout. Next word appears the cycle after release, with no bubble because the buffer is FULL.
- Reseed request: RESEED_INTERVAL=4, rdi_ready=1 → reseed_req rises after the 4th handshake. A seed accept drops it on the same edge.
- Mid-fill reseed: reseed one cycle into FILL → the partial word is discarded; the next delivered word matches the new seed's golden output.
- Reset mid-operation: assert rst=0 while rdi_valid=1 → next edge gives rdi_valid=0, seed_ready=1, rdi_data=0. No output until a new seed is accepted.
